// File: rtl/proc_pkg.sv
// Shared processor definitions: instruction-register layout, opcodes,
// decoded-field struct and the fetch FSM state type.
package proc_pkg;

    localparam int IW = 32;

    localparam int OPER_MSB  = 31;
    localparam int OPER_LSB  = 27;
    localparam int RDST_MSB  = 26;
    localparam int RDST_LSB  = 22;
    localparam int RSRC1_MSB = 21;
    localparam int RSRC1_LSB = 17;
    localparam int IMM_BIT   = 16;
    localparam int RSRC2_MSB = 15;
    localparam int RSRC2_LSB = 11;
    localparam int ISRC_MSB  = 15;
    localparam int ISRC_LSB  = 0;

    typedef enum logic [4:0] {
        OPC_NOP  = 5'd0,
        OPC_ADD  = 5'd1,
        OPC_SUB  = 5'd2,
        OPC_AND  = 5'd3,
        OPC_OR   = 5'd4,
        OPC_XOR  = 5'd5,
        OPC_SHL  = 5'd6,
        OPC_SHR  = 5'd7,
        OPC_LD   = 5'd8,
        OPC_ST   = 5'd9,
        OPC_BR   = 5'd10,
        OPC_HALT = 5'd11
    } opcode_e;

    localparam logic [4:0] OPC_MAX = 5'd11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [4:0]  oper_type;
        logic [4:0]  rdst;
        logic [4:0]  rsrc1;
        logic        imm_mode;
        logic [4:0]  rsrc2;
        logic [15:0] isrc;
    } ir_fields_t;

endpackage

// File: rtl/ir_field_decode.sv
// Slices an instruction word into its fields and flags unknown opcodes.
// Purely combinational so the execute stage can reuse it unchanged.
module ir_field_decode
    import proc_pkg::*;
(
    input  logic [IW-1:0] ir,
    output ir_fields_t    fields,
    output logic          illegal
);

    assign fields.oper_type = ir[OPER_MSB:OPER_LSB];
    assign fields.rdst      = ir[RDST_MSB:RDST_LSB];
    assign fields.rsrc1     = ir[RSRC1_MSB:RSRC1_LSB];
    assign fields.imm_mode  = ir[IMM_BIT];
    assign fields.rsrc2     = ir[RSRC2_MSB:RSRC2_LSB];
    assign fields.isrc      = ir[ISRC_MSB:ISRC_LSB];

    assign illegal = (ir[OPER_MSB:OPER_LSB] > OPC_MAX);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding program-memory read at a time,
// loads the instruction register and hands it to execute with valid/ready.
module instr_fetch #(
    parameter int                ADDR_W   = 8,
    parameter int                IW       = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   imem_req,
    output logic [ADDR_W-1:0]      imem_addr,
    input  logic [IW-1:0]          imem_rdata,
    input  logic                   imem_rvalid,
    output logic [IW-1:0]          ir,
    output logic                   ir_valid,
    input  logic                   ir_ready,
    output logic                   illegal_op,
    output logic [ADDR_W-1:0]      pc,
    input  logic                   branch_en,
    input  logic [ADDR_W-1:0]      branch_addr,
    input  logic                   halt,
    output proc_pkg::ir_fields_t   ir_fields,
    output proc_pkg::fetch_state_e dbg_state
);
    import proc_pkg::*;

    // Handshake: ir is transferred in a cycle where ir_valid && ir_ready at the
    // rising edge; ir/pc/ir_valid hold steady while ir_valid && !ir_ready.

    fetch_state_e      state, state_nx;
    logic [ADDR_W-1:0] fetch_pc, fetch_pc_nx;
    logic              drop, drop_nx;
    logic              load_ir;
    logic              handshake;
    logic              ir_illegal;

    assign handshake = ir_valid && ir_ready;
    assign dbg_state = state;

    always_comb begin
        state_nx    = state;
        fetch_pc_nx = fetch_pc;
        drop_nx     = drop;
        imem_req    = 1'b0;
        load_ir     = 1'b0;

        // A response owed to an abandoned request retires the drop flag.
        if (drop && imem_rvalid) begin
            drop_nx = 1'b0;
        end

        case (state)
            IDLE: begin
                if (!halt) begin
                    state_nx = FETCH;
                end
            end
            FETCH: begin
                // Never issue while the abandoned request is still in flight.
                if (halt) begin
                    state_nx = IDLE;
                end else if (!drop) begin
                    imem_req = 1'b1;
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    load_ir     = 1'b1;
                    fetch_pc_nx = fetch_pc + ADDR_W'(1);
                    state_nx    = HOLD;
                end
            end
            HOLD: begin
                if (handshake) begin
                    state_nx = halt ? IDLE : FETCH;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        if (branch_en) begin
            load_ir     = 1'b0;
            fetch_pc_nx = branch_addr;
            state_nx    = halt ? IDLE : FETCH;
            // A request left unanswered by the redirect must be swallowed later.
            if ((state == WAIT && !imem_rvalid) || imem_req) begin
                drop_nx = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            drop     <= 1'b0;
            ir       <= '0;
            ir_valid <= 1'b0;
            pc       <= '0;
        end else begin
            state    <= state_nx;
            fetch_pc <= fetch_pc_nx;
            drop     <= drop_nx;
            if (load_ir) begin
                ir       <= imem_rdata;
                pc       <= fetch_pc;
                ir_valid <= 1'b1;
            end else if (handshake || branch_en) begin
                ir_valid <= 1'b0;
            end
        end
    end

    assign imem_addr = imem_req ? fetch_pc : '0;

    ir_field_decode u_decode (
        .ir      (ir[proc_pkg::IW-1:0]),
        .fields  (ir_fields),
        .illegal (ir_illegal)
    );

    assign illegal_op = ir_valid && ir_illegal;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus a random run, all checked
// against a transaction-level model of the fetch/deliver/redirect rules.
module tb_instr_fetch;
  import proc_pkg::*;

  localparam int AW = 8;
  localparam int W  = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          imem_req, imem_rvalid, ir_valid, ir_ready, illegal_op;
  logic          branch_en, halt;
  logic [AW-1:0] imem_addr, pc, branch_addr;
  logic [W-1:0]  imem_rdata, ir;
  ir_fields_t    ir_fields;
  fetch_state_e  dbg_state;

  logic          imem_req2, imem_rvalid2, ir_valid2, ir_ready2, illegal_op2;
  logic          branch_en2, halt2;
  logic [AW-1:0] imem_addr2, pc2, branch_addr2;
  logic [W-1:0]  imem_rdata2, ir2;
  ir_fields_t    ir_fields2;
  fetch_state_e  dbg_state2;

  instr_fetch #(.ADDR_W(AW), .IW(W), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid), .ir(ir), .ir_valid(ir_valid),
    .ir_ready(ir_ready), .illegal_op(illegal_op), .pc(pc), .branch_en(branch_en),
    .branch_addr(branch_addr), .halt(halt), .ir_fields(ir_fields), .dbg_state(dbg_state)
  );

  instr_fetch #(.ADDR_W(AW), .IW(W), .RESET_PC(8'hFF)) dut_top_pc (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_rdata(imem_rdata2), .imem_rvalid(imem_rvalid2), .ir(ir2), .ir_valid(ir_valid2),
    .ir_ready(ir_ready2), .illegal_op(illegal_op2), .pc(pc2), .branch_en(branch_en2),
    .branch_addr(branch_addr2), .halt(halt2), .ir_fields(ir_fields2), .dbg_state(dbg_state2)
  );

  int checks = 0;
  int errors = 0;

  // memory model and reference model state
  logic [W-1:0]      mem [256];
  bit                pend, p_cancel, exp_valid, req2_prev;
  int                cnt, lat_fix, cyc, stale_cyc;
  logic [AW-1:0]     p_addr, exp_fetch, exp_pc;
  logic [W-1:0]      exp_ir;
  logic [AW+W-1:0]   exp_q[$];
  logic [AW-1:0]     req_log[$], req2_log[$], dv_pc[$];
  int                req_cyc[$];
  logic [W-1:0]      dv_ir[$];
  logic [4:0]        dv_op[$];
  logic              dv_ill[$];

  typedef struct {
    logic [31:0] word;
    logic [4:0]  oper;
    logic        ill;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive memory response, check outputs, advance the model.
  task automatic cycle();
    bit            resp, resp_cancel;
    logic [AW-1:0] resp_addr;
    resp = 1'b0;
    resp_cancel = 1'b0;
    resp_addr = '0;
    imem_rvalid = 1'b0;
    imem_rdata = $urandom();
    if (pend && cnt <= 0) begin
      resp = 1'b1;
      resp_cancel = p_cancel;
      resp_addr = p_addr;
      pend = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata = p_cancel ? 32'hDEAD_BEEF : mem[p_addr];
      if (p_cancel) stale_cyc = cyc;
    end
    imem_rvalid2 = req2_prev;
    imem_rdata2 = '0;
    #1;
    if (!rst_n) begin
      exp_q.delete();
      exp_valid = 1'b0;
      exp_fetch = 8'h00;
      if (pend) p_cancel = 1'b1;
    end else if (exp_q.size() > 0) begin
      {exp_pc, exp_ir} = exp_q.pop_front();
      exp_valid = 1'b1;
    end
    chk("ir_valid", 32'(ir_valid), 32'(exp_valid));
    if (exp_valid) begin
      chk("ir", ir, exp_ir);
      chk("pc", 32'(pc), 32'(exp_pc));
    end
    chk("illegal_op", 32'(illegal_op), 32'(exp_valid && (exp_ir[31:27] > 5'd11)));
    if (rst_n) begin
      if (imem_req) begin
        chk("req_while_halt", 32'(halt), 32'd0);
        chk("req_addr", 32'(imem_addr), 32'(exp_fetch));
        chk("one_outstanding", 32'(pend), 32'd0);
        pend = 1'b1;
        p_cancel = 1'b0;
        p_addr = imem_addr;
        cnt = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 4));
        req_log.push_back(imem_addr);
        req_cyc.push_back(cyc);
      end
      if (exp_valid && ir_ready) begin
        dv_pc.push_back(pc);
        dv_ir.push_back(ir);
        dv_op.push_back(ir_fields.oper_type);
        dv_ill.push_back(illegal_op);
      end
      if (exp_valid && (ir_ready || branch_en)) exp_valid = 1'b0;
      if (branch_en) begin
        if (pend) p_cancel = 1'b1;
        exp_fetch = branch_addr;
      end else if (resp && !resp_cancel) begin
        exp_q.push_back({resp_addr, mem[resp_addr]});
        exp_fetch = resp_addr + 8'd1;
      end
    end
    if (imem_req2) req2_log.push_back(imem_addr2);
    req2_prev = imem_req2;
    @(posedge clk);
    #1;
    cyc++;
    if (pend) cnt--;
  endtask

  task automatic do_reset(input bit stale);
    rst_n = 1'b0;
    branch_en = 1'b0;
    branch_addr = '0;
    ir_ready = 1'b0;
    halt = 1'b0;
    #1;
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'd0);
    chk("rst_ir", ir, 32'd0);
    chk("rst_ir_valid", 32'(ir_valid), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    cycle();
    cycle();
    pend = stale;
    cnt = 0;
    p_cancel = 1'b1;
    rst_n = 1'b1;
    req_log.delete();
    req_cyc.delete();
    req2_log.delete();
    dv_pc.delete();
    dv_ir.delete();
    dv_op.delete();
    dv_ill.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    logic [W-1:0] w;
    ir_ready2 = 1'b1; halt2 = 1'b0; branch_en2 = 1'b0; branch_addr2 = '0;
    imem_rvalid2 = 1'b0; imem_rdata2 = '0; imem_rvalid = 1'b0; imem_rdata = '0;
    ir_ready = 1'b0; halt = 1'b0; branch_en = 1'b0; branch_addr = '0;
    pend = 0; p_cancel = 0; exp_valid = 0; req2_prev = 0; cnt = 0; cyc = 0; stale_cyc = -1;
    exp_fetch = '0; exp_pc = '0; exp_ir = '0; p_addr = '0; lat_fix = 1;

    tbl[0] = '{32'h1040_0002, 5'd2,  1'b0};
    tbl[1] = '{32'h1000_0004, 5'd2,  1'b0};
    tbl[2] = '{32'h2000_0037, 5'd4,  1'b0};
    tbl[3] = '{32'h5800_0000, 5'd11, 1'b0};
    tbl[4] = '{32'h6000_0000, 5'd12, 1'b1};
    tbl[5] = '{32'hF800_0000, 5'd31, 1'b1};
    tbl[6] = '{32'h0000_0000, 5'd0,  1'b0};
    tbl[7] = '{32'h6800_1234, 5'd13, 1'b1};

    for (int i = 0; i < 256; i++) begin
      w = $urandom();
      w[31:27] = 5'($urandom_range(0, 15));
      mem[i] = w;
    end

    // table vectors, latency 1, ready tied high; also the RESET_PC=0xFF instance
    for (int i = 0; i < 8; i++) mem[i] = tbl[i].word;
    do_reset(1'b0);
    lat_fix = 1;
    ir_ready = 1'b1;
    for (int c = 0; c < 200 && dv_pc.size() < 8; c++) cycle();
    chk("p1_deliveries", 32'(dv_pc.size()), 32'd8);
    for (int i = 0; i < 8 && i < dv_pc.size(); i++) begin
      chk("p1_ir", dv_ir[i], tbl[i].word);
      chk("p1_pc", 32'(dv_pc[i]), 32'(i));
      chk("p1_oper_type", 32'(dv_op[i]), 32'(tbl[i].oper));
      chk("p1_illegal", 32'(dv_ill[i]), 32'(tbl[i].ill));
    end
    chk("p1_req_count", 32'(req_log.size() >= 3), 32'd1);
    if (req_log.size() >= 3) begin
      for (int i = 0; i < 3; i++) chk("p1_req_order", 32'(req_log[i]), 32'(i));
      chk("p1_period_lat1", 32'(req_cyc[1] - req_cyc[0]), 32'd3);
      chk("p1_period_lat1b", 32'(req_cyc[2] - req_cyc[1]), 32'd3);
    end
    chk("u2_req_count", 32'(req2_log.size() >= 2), 32'd1);
    if (req2_log.size() >= 2) begin
      chk("u2_first_addr", 32'(req2_log[0]), 32'h0FF);
      chk("u2_wrap_addr", 32'(req2_log[1]), 32'h000);
    end

    // latency 3, execute stalls for 5 cycles while HOLD
    do_reset(1'b0);
    lat_fix = 3;
    ir_ready = 1'b0;
    for (int c = 0; c < 20 && !ir_valid; c++) cycle();
    chk("p2_ir_valid_seen", 32'(ir_valid), 32'd1);
    n0 = req_log.size();
    repeat (5) cycle();
    chk("p2_no_req_in_hold", 32'(req_log.size()), 32'(n0));
    chk("p2_ir_stable", ir, mem[0]);
    chk("p2_pc_stable", 32'(pc), 32'd0);
    ir_ready = 1'b1;
    cycle();
    ir_ready = 1'b0;
    repeat (6) cycle();
    chk("p2_one_req_after_hs", 32'(req_log.size()), 32'(n0 + 1));
    if (req_log.size() == n0 + 1) chk("p2_next_addr", 32'(req_log[n0]), 32'd1);
    ir_ready = 1'b1;
    for (int c = 0; c < 60 && req_log.size() < n0 + 4; c++) cycle();
    chk("p2_req_count", 32'(req_log.size() >= n0 + 4), 32'd1);
    if (req_log.size() >= n0 + 4) begin
      chk("p2_period_lat3a", 32'(req_cyc[n0 + 2] - req_cyc[n0 + 1]), 32'd5);
      chk("p2_period_lat3b", 32'(req_cyc[n0 + 3] - req_cyc[n0 + 2]), 32'd5);
    end

    // redirect during WAIT; the stale response must be swallowed
    mem[8'h40] = 32'h0840_1234;
    do_reset(1'b0);
    lat_fix = 3;
    ir_ready = 1'b1;
    for (int c = 0; c < 10 && req_log.size() == 0; c++) cycle();
    chk("p3_first_req", 32'(req_log.size()), 32'd1);
    branch_en = 1'b1;
    branch_addr = 8'h40;
    cycle();
    branch_en = 1'b0;
    for (int c = 0; c < 40 && dv_pc.size() == 0; c++) cycle();
    chk("p3_delivered", 32'(dv_pc.size() >= 1), 32'd1);
    if (dv_pc.size() >= 1) begin
      chk("p3_pc", 32'(dv_pc[0]), 32'h40);
      chk("p3_ir", dv_ir[0], 32'h0840_1234);
    end
    chk("p3_req_count", 32'(req_log.size() >= 2), 32'd1);
    if (req_log.size() >= 2) begin
      chk("p3_branch_addr", 32'(req_log[1]), 32'h40);
      chk("p3_req_after_stale", 32'(req_cyc[1] > stale_cyc), 32'd1);
    end

    // illegal opcode, then halt after the handshake
    mem[0] = 32'h6000_0000;
    mem[1] = 32'h0800_0001;
    do_reset(1'b0);
    lat_fix = 1;
    ir_ready = 1'b0;
    for (int c = 0; c < 20 && !ir_valid; c++) cycle();
    chk("p4_ir_valid_seen", 32'(ir_valid), 32'd1);
    chk("p4_illegal_op", 32'(illegal_op), 32'd1);
    chk("p4_oper_type", 32'(ir_fields.oper_type), 32'd12);
    halt = 1'b1;
    ir_ready = 1'b1;
    cycle();
    ir_ready = 1'b0;
    n0 = req_log.size();
    repeat (6) cycle();
    chk("p4_no_req_halted", 32'(req_log.size()), 32'(n0));
    halt = 1'b0;
    for (int c = 0; c < 10 && req_log.size() == n0; c++) cycle();
    chk("p4_resume", 32'(req_log.size()), 32'(n0 + 1));
    if (req_log.size() > n0) chk("p4_resume_addr", 32'(req_log[n0]), 32'd1);

    // reset in the middle of WAIT, response arrives after release
    do_reset(1'b0);
    lat_fix = 3;
    ir_ready = 1'b1;
    for (int c = 0; c < 10 && req_log.size() == 0; c++) cycle();
    chk("p5_first_req", 32'(req_log.size()), 32'd1);
    cycle();
    do_reset(1'b1);
    cycle();
    chk("p5_ir_valid_after_stale", 32'(ir_valid), 32'd0);
    for (int c = 0; c < 10 && req_log.size() == 0; c++) cycle();
    chk("p5_req_after_reset", 32'(req_log.size()), 32'd1);
    if (req_log.size() >= 1) chk("p5_req_addr", 32'(req_log[0]), 32'd0);

    // random traffic against the model
    for (int i = 0; i < 256; i++) begin
      w = $urandom();
      w[31:27] = 5'($urandom_range(0, 15));
      mem[i] = w;
    end
    do_reset(1'b0);
    lat_fix = 0;
    for (int c = 0; c < 3000; c++) begin
      ir_ready = ($urandom_range(0, 3) != 0);
      branch_en = ($urandom_range(0, 11) == 0);
      branch_addr = 8'($urandom());
      if ($urandom_range(0, 24) == 0) halt = ~halt;
      cycle();
    end
    branch_en = 1'b0;
    halt = 1'b0;
    chk("rand_progress", 32'(dv_pc.size() > 50), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter ADDR_W, default 8, program-memory word-address width.
REQ-002 Parameter IW, default 32, instruction width.
REQ-003 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 imem_req  out  1  one-cycle read request to program memory.
REQ-008 imem_addr  out  ADDR_W  read address, valid while imem_req=1.
REQ-009 imem_rdata  in  IW  read data, valid while imem_rvalid=1.
REQ-010 imem_rvalid  in  1  read response strobe, 1..N cycles after imem_req.
REQ-011 ir  out  IW  instruction register presented to the execute stage.
REQ-012 ir_valid  out  1  ir holds an unconsumed instruction.
REQ-013 ir_ready  in  1  execute stage accepts ir this cycle.
REQ-014 illegal_op  out  1  ir[31:27] (oper_type) > 11, qualified by ir_valid.
REQ-015 pc  out  ADDR_W  address of the instruction in ir.
REQ-016 branch_en  in  1  redirect request; branch_addr  in  ADDR_W  redirect target.
REQ-017 halt  in  1  level; while 1 no new request is issued.

Function
REQ-018 FSM states: IDLE, FETCH, WAIT, HOLD; reset state IDLE.
REQ-019 IDLE -> FETCH next cycle when halt=0; stays in IDLE while halt=1.
REQ-020 FETCH: imem_req=1 for exactly one cycle with imem_addr=fetch_pc; -> WAIT.
REQ-021 WAIT: on imem_rvalid=1, ir<=imem_rdata, pc<=fetch_pc, fetch_pc<=fetch_pc+1, ir_valid=1 from next cycle; -> HOLD.
REQ-022 Response latency is unbounded; WAIT holds with no timeout; at most one request outstanding.
REQ-023 HOLD: ir, pc, ir_valid stable until ir_ready=1; on handshake ir_valid<=0 and -> FETCH (halt=0) or IDLE (halt=1).
REQ-024 fetch_pc SHALL wrap from 2^ADDR_W-1 to 0 with no flag.
REQ-025 branch_en=1 in any state: fetch_pc<=branch_addr, ir_valid<=0, -> FETCH (halt=0) or IDLE (halt=1) next cycle.
REQ-026 branch_en during WAIT: the pending response SHALL be discarded (drop flag), not loaded into ir; the next request waits until it arrives.
REQ-027 branch_en and ir_ready in the same cycle: the handshake completes; branch target is fetched next.
REQ-028 branch_en and imem_rvalid in the same cycle: the response is discarded.
REQ-029 imem_rvalid in IDLE, FETCH or HOLD (no outstanding request) SHALL be ignored.
REQ-030 illegal_op is combinational from ir; the block does not stall on it.
REQ-031 Steady-state throughput: one instruction per (3 + memory latency - 1) cycles with ir_ready tied 1.

Reset
REQ-032 rst_n=0 asynchronously forces: state=IDLE, imem_req=0, imem_addr=0, ir=0, ir_valid=0, pc=0, fetch_pc=RESET_PC, drop flag=0.
REQ-033 Reset during WAIT: a response arriving after release SHALL be ignored (REQ-029).

Structure
REQ-034 Shared package proc_pkg: IW, IR field positions (oper_type[31:27], rdst[26:22], rsrc1[21:17], imm_mode[16], rsrc2[15:11], isrc[15:0]), opcode constants 0..11, OPC_MAX=11, FSM state enum.
REQ-035 One combinational sub-module ir_field_decode (field slicing plus illegal check), reused by the execute stage.

Verification
REQ-036 Reset release, memory latency 1, ir_ready=1, mem[0..2]=0x1040_0002,0x1000_0004,0x2000_0037 -> imem_addr 0,1,2 in order; ir matches with pc 0,1,2; illegal_op=0.
REQ-037 Latency 3, ir_ready=0 for 5 cycles after ir_valid -> ir/pc stable, no imem_req while HOLD; one request follows the handshake.
REQ-038 branch_en with branch_addr=0x40 during WAIT; stale data 0xDEAD_BEEF returns -> discarded; next ir from addr 0x40, pc=0x40.
REQ-039 Start at RESET_PC=0xFF -> fetch addresses 0xFF then 0x00.
REQ-040 mem[0]=0x6000_0000 (oper_type 12) -> ir_valid=1, illegal_op=1; halt=1 after handshake -> no imem_req; halt=0 -> fetch resumes at addr 1.
REQ-041 rst_n low mid-WAIT, rvalid pulsed after release -> ir_valid stays 0; first request after release at RESET_PC.
